regfile_mp: RTL and testbench

- Parametrised multi-port register file with an integrated pending-write scoreboard, for the pipelined LC2K core and its wider successors.
- Provides NUM_RD registered read ports and NUM_WR write ports.
- Reads see same-cycle writes through a write-to-read bypass.
- A per-register pending bit lets decode detect RAW hazards without a separate scoreboard block.

---
 rtl/lc2k_pkg.sv | 20 ++
 rtl/regfile_mp_if.sv | 34 +++
 rtl/regfile_bypass_mux.sv | 33 +++
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared constants and types for the LC2K core datapath.
//   LC2K_DATA_W / LC2K_NUM_REGS : default word width and register count
//   reg_addr_t / word_t         : register address and data word at the defaults
//   wr_req_t                    : one writeback request (enable, address, data)
package lc2k_pkg;

  localparam int LC2K_DATA_W   = 32;
  localparam int LC2K_NUM_REGS = 8;
  localparam int LC2K_AW       = $clog2(LC2K_NUM_REGS);

  typedef logic [LC2K_AW-1:0]     reg_addr_t;
  typedef logic [LC2K_DATA_W-1:0] word_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    word_t     data;
  } wr_req_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of read, write and reserve signals for regfile_mp.
//   master : pipeline side, drives requests and receives read results
//   slave  : register file side
interface regfile_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD-1:0]             rd_en;
  logic [NUM_RD-1:0][AW-1:0]     rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_valid;
  logic [NUM_RD-1:0]             rd_pending;
  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][AW-1:0]     wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic                          rsv_en;
  logic [AW-1:0]                 rsv_addr;
  logic                          any_pending;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_valid, rd_pending, any_pending
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_valid, rd_pending, any_pending
  );

endinterface

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: read-data select for one read port.
//   rd_addr_i  : address being read
//   wr_en_i/wr_addr_i/wr_data_i : this cycle's write ports
//   reg_data_i : stored value of the addressed register
//   rd_data_o  : zero-register override, else youngest matching write, else storage
module regfile_bypass_mux #(
  parameter int DATA_W   = 32,
  parameter int AW       = 3,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]                 rd_addr_i,
  input  logic [NUM_WR-1:0]             wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0]             reg_data_i,
  output logic [DATA_W-1:0]             rd_data_o
);

  always_comb begin
    rd_data_o = reg_data_i;
    // Ascending scan so the highest-index matching port overrides the rest.
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i)) begin
        rd_data_o = wr_data_i[w];
      end
    end
    if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and a
// per-register pending bit for RAW hazard detection.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : regfile_mp_if slave (reads, writes, reserve, pending status)
module regfile_mp
  import lc2k_pkg::*;
#(
  parameter int DATA_W   = LC2K_DATA_W,
  parameter int NUM_REGS = LC2K_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]             regs_q [NUM_REGS];
  logic [DATA_W-1:0]             regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]           pend_q, pend_d;
  logic [NUM_REGS-1:0]           wr_hit;
  logic [NUM_REGS-1:0]           pend_clr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_d;
  logic [NUM_RD-1:0]             rd_valid_q;
  logic [NUM_RD-1:0]             rd_pend_q, rd_pend_d;

  // Storage next-state; later write ports override earlier ones.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      wr_hit[r] = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w] == AW'(r))) begin
          regs_d[r] = bus.wr_data[w];
          wr_hit[r] = 1'b1;
        end
      end
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      wr_hit[0] = 1'b0;
    end
  end

  // Completing writes clear first; a same-cycle reserve then re-sets the bit,
  // since the reserving instruction is a newer producer.
  assign pend_clr = pend_q & ~wr_hit;

  always_comb begin
    pend_d = pend_clr;
    if (bus.rsv_en) begin
      pend_d[bus.rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      pend_d[0] = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_bypass_mux #(
      .DATA_W   (DATA_W),
      .AW       (AW),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_mux (
      .rd_addr_i  (bus.rd_addr[i]),
      .wr_en_i    (bus.wr_en),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .reg_data_i (regs_q[bus.rd_addr[i]]),
      .rd_data_o  (rd_data_d[i])
    );

    // Sampled after write-clear, before reserve-set.
    assign rd_pend_d[i] = pend_clr[bus.rd_addr[i]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      pend_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_pend_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      rd_valid_q <= bus.rd_en;
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.rd_en[i]) begin
          rd_data_q[i] <= rd_data_d[i];
          rd_pend_q[i] <= rd_pend_d[i];
        end
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_pending  = rd_pend_q;
  assign bus.any_pending = |pend_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] vld;
    logic       anyp;
  } rec_t;

  rec_t        recq[$];
  logic [32:0] pq0[$];
  logic [32:0] pq1[$];

  // Reference model: architectural state as seen after each clock edge.
  logic [31:0] mregs [8];
  logic        mpend [8];
  logic [32:0] last_exp [2];

  int  n_cmp = 0;
  int  n_err = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      mregs[r] = '0;
      mpend[r] = 1'b0;
    end
    last_exp[0] = '0;
    last_exp[1] = '0;
    recq.delete();
    pq0.delete();
    pq1.delete();
  endtask

  task automatic drive_idle();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  // Called at a falling edge: drives one cycle of stimulus, queues the
  // expected results, and advances the model to the post-edge state.
  task automatic cyc(input logic [1:0] re, input logic [2:0] ra0, input logic [2:0] ra1,
                     input logic [1:0] we, input logic [2:0] wa0, input logic [2:0] wa1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic rs, input logic [2:0] rsa);
    logic [2:0]  ra [2];
    logic [2:0]  wa [2];
    logic [31:0] wd [2];
    logic        written [8];
    logic [31:0] ed;
    logic        ep;
    logic        anyp;
    rec_t        rec;
    ra[0] = ra0; ra[1] = ra1;
    wa[0] = wa0; wa[1] = wa1;
    wd[0] = wd0; wd[1] = wd1;

    bus.rd_en      = re;
    bus.rd_addr[0] = ra0;
    bus.rd_addr[1] = ra1;
    bus.wr_en      = we;
    bus.wr_addr[0] = wa0;
    bus.wr_addr[1] = wa1;
    bus.wr_data[0] = wd0;
    bus.wr_data[1] = wd1;
    bus.rsv_en     = rs;
    bus.rsv_addr   = rsa;

    for (int r = 0; r < 8; r++) written[r] = 1'b0;
    for (int w = 0; w < 2; w++)
      if (we[w] && wa[w] != 3'd0) written[wa[w]] = 1'b1;

    for (int i = 0; i < 2; i++) begin
      if (re[i]) begin
        if (ra[i] == 3'd0) begin
          ed = 32'd0;
        end else begin
          ed = mregs[ra[i]];
          if (we[0] && wa[0] == ra[i]) ed = wd[0];
          if (we[1] && wa[1] == ra[i]) ed = wd[1];
        end
        ep = mpend[ra[i]] && !written[ra[i]];
        if (i == 0) pq0.push_back({ep, ed});
        else        pq1.push_back({ep, ed});
      end
    end

    for (int w = 0; w < 2; w++)
      if (we[w] && wa[w] != 3'd0) mregs[wa[w]] = wd[w];
    for (int r = 0; r < 8; r++)
      if (written[r]) mpend[r] = 1'b0;
    if (rs && rsa != 3'd0) mpend[rsa] = 1'b1;

    anyp = 1'b0;
    for (int r = 0; r < 8; r++) anyp = anyp | mpend[r];
    rec.vld  = re;
    rec.anyp = anyp;
    recq.push_back(rec);
  endtask

  task automatic idle_cyc();
    cyc(2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0);
  endtask

  // Monitor: consumes one cycle record per edge and compares whatever the DUT presents.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (recq.size() == 0) begin
        chk("rec_queue_underflow", 64'd1, 64'd0);
      end else begin
        rec_t        rec;
        logic [32:0] e;
        rec = recq.pop_front();
        chk("rd_valid", 64'(bus.rd_valid), 64'(rec.vld));
        chk("any_pending", 64'(bus.any_pending), 64'(rec.anyp));
        for (int i = 0; i < 2; i++) begin
          if (bus.rd_valid[i]) begin
            if ((i == 0 && pq0.size() == 0) || (i == 1 && pq1.size() == 0)) begin
              chk("rd_queue_underflow", 64'd1, 64'd0);
            end else begin
              e = (i == 0) ? pq0.pop_front() : pq1.pop_front();
              last_exp[i] = e;
            end
          end
          chk(i == 0 ? "rd_data0" : "rd_data1", 64'(bus.rd_data[i]), 64'(last_exp[i][31:0]));
          chk(i == 0 ? "rd_pending0" : "rd_pending1", 64'(bus.rd_pending[i]), 64'(last_exp[i][32]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rd_data", 64'(bus.rd_data), 64'd0);
    chk("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("reset_rd_pending", 64'(bus.rd_pending), 64'd0);
    chk("reset_any_pending", 64'(bus.any_pending), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // All registers read zero after reset.
    for (int r = 0; r < 8; r++) begin
      cyc(2'b11, 3'(r), 3'(r), 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0);
      @(negedge clk);
    end

    // Plain write then read on both ports.
    cyc(2'b00, 3'd0, 3'd0, 2'b01, 3'd3, 3'd0, 32'h0000_00AA, 32'd0, 1'b0, 3'd0);
    @(negedge clk);
    cyc(2'b11, 3'd3, 3'd3, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0);
    @(negedge clk);

    // Colliding writes with same-cycle bypass read, then a stored read.
    cyc(2'b01, 3'd5, 3'd0, 2'b11, 3'd5, 3'd5, 32'h0000_1234, 32'h0000_5678, 1'b0, 3'd0);
    @(negedge clk);
    cyc(2'b11, 3'd5, 3'd5, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0);
    @(negedge clk);

    // Register 0 ignores writes and reserves.
    cyc(2'b00, 3'd0, 3'd0, 2'b01, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 3'd0);
    @(negedge clk);
    cyc(2'b11, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0);
    @(negedge clk);

    // Scoreboard sequence on r2.
    cyc(2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b1, 3'd2);
    @(negedge clk);
    cyc(2'b01, 3'd2, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0);
    @(negedge clk);
    cyc(2'b10, 3'd0, 3'd2, 2'b01, 3'd2, 3'd0, 32'd7, 32'd0, 1'b1, 3'd2);
    @(negedge clk);
    cyc(2'b01, 3'd2, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0);
    @(negedge clk);
    cyc(2'b11, 3'd2, 3'd2, 2'b10, 3'd0, 3'd2, 32'd0, 32'd9, 1'b0, 3'd0);
    @(negedge clk);
    idle_cyc();
    @(negedge clk);

    // Reserve r6, then reset in the middle of the following cycle.
    cyc(2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b1, 3'd6);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("midreset_rd_data", 64'(bus.rd_data), 64'd0);
    chk("midreset_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("midreset_rd_pending", 64'(bus.rd_pending), 64'd0);
    chk("midreset_any_pending", 64'(bus.any_pending), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc(2'b01, 3'd6, 3'd0, 2'b01, 3'd4, 3'd0, 32'h0000_CAFE, 32'd0, 1'b0, 3'd0);
    @(negedge clk);
    cyc(2'b11, 3'd4, 3'd6, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0);
    @(negedge clk);

    // Randomized traffic.
    repeat (400) begin
      cyc(2'($urandom), 3'($urandom), 3'($urandom),
          2'($urandom), 3'($urandom), 3'($urandom),
          $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
          ($urandom_range(0, 2) == 0), 3'($urandom));
      @(negedge clk);
    end
    idle_cyc();
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("drain_records", 64'(recq.size()), 64'd0);
    chk("drain_port0", 64'(pq0.size()), 64'd0);
    chk("drain_port1", 64'(pq1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
